bram_block_copy: RTL and testbench

//   Parametrised BRAM-to-BRAM copy engine. It reads LEN consecutive words from BRAM port A,

---
 rtl/bram_block_copy.sv | 193 +++++++++++++++++++
 tb/tb_bram_block_copy.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_block_copy.sv
// bram_block_copy: copies len words from BRAM port A (src_base) to port B (dst_base), one read per cycle.
// Optional feature macro BRAM_COPY_CHECKSUM_EN adds a modulo-2^DATA_W running sum of written words.
module bram_block_copy #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 16,
  parameter int ADDR_INC = 4,
  parameter int RD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [ADDR_W-1:0]     src_base,
  input  logic [ADDR_W-1:0]     dst_base,
  output logic                  ready,
  output logic                  done,
  output logic                  clka,
  output logic                  clkb,
  output logic                  rsta,
  output logic                  rstb,
  output logic                  ena,
  output logic [ADDR_W-1:0]     addra,
  output logic [DATA_W-1:0]     dina,
  output logic [DATA_W/8-1:0]   wea,
  input  logic [DATA_W-1:0]     douta,
  output logic                  enb,
  output logic [ADDR_W-1:0]     addrb,
  output logic [DATA_W-1:0]     dinb,
  output logic [DATA_W/8-1:0]   web,
`ifdef BRAM_COPY_CHECKSUM_EN
  output logic [DATA_W-1:0]     checksum,
`endif
  input  logic [DATA_W-1:0]     doutb
);

  localparam int WE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(ADDR_INC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_reg;
  logic                start_q_reg;
  logic                ready_reg;
  logic                done_reg;
  logic                ena_reg;
  logic [ADDR_W-1:0]   addra_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    rd_cnt_reg;
  logic                enb_reg;
  logic [WE_W-1:0]     web_reg;
  logic [ADDR_W-1:0]   addrb_reg;
  logic [DATA_W-1:0]   dinb_reg;
  logic [LEN_W-1:0]    wr_cnt_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [RD_LAT-1:0]   vld_reg;
  logic [RD_LAT-1:0]   vld_next;
  logic                accept;
  logic                rd_vld;
  logic                unused_ok;

  assign clka  = clk;
  assign clkb  = clk;
  assign rsta  = rst;
  assign rstb  = rst;
  assign dina  = '0;
  assign wea   = '0;
  assign ready = ready_reg;
  assign done  = done_reg;
  assign ena   = ena_reg;
  assign addra = addra_reg;
  assign enb   = enb_reg;
  assign addrb = addrb_reg;
  assign dinb  = dinb_reg;
  assign web   = web_reg;

  assign unused_ok = ^doutb;

  // A job is launched only on a rising edge of start; the DONE cycle also counts as idle.
  assign accept = ((state_reg == IDLE) || (state_reg == DONE)) && ready_reg && start && !start_q_reg;

  // Valid pipe: bit k high means a read issued k+1 cycles ago is in flight.
  assign vld_next[0] = ena_reg;
  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld
    assign vld_next[gi] = vld_reg[gi-1];
  end

  assign rd_vld = vld_reg[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= vld_next;
    end
  end

  // Control FSM and read side
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      start_q_reg <= 1'b0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
      ena_reg     <= 1'b0;
      addra_reg   <= '0;
      len_reg     <= '0;
      rd_cnt_reg  <= '0;
    end else begin
      start_q_reg <= start;
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          if (accept) begin
            len_reg    <= len;
            rd_cnt_reg <= LEN_W'(1);
            if (len == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              ready_reg <= 1'b0;
              ena_reg   <= 1'b1;
              addra_reg <= src_base;
            end
          end
        end
        RUN: begin
          if (rd_cnt_reg == len_reg) begin
            ena_reg   <= 1'b0;
            state_reg <= DRAIN;
          end else begin
            addra_reg  <= addra_reg + INC;
            rd_cnt_reg <= rd_cnt_reg + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (wr_cnt_reg == len_reg) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write side: each returning word is captured and presented to port B on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      enb_reg     <= 1'b0;
      web_reg     <= '0;
      addrb_reg   <= '0;
      dinb_reg    <= '0;
      wr_cnt_reg  <= '0;
      wr_addr_reg <= '0;
    end else begin
      enb_reg <= rd_vld;
      web_reg <= {WE_W{rd_vld}};
      if (accept) begin
        wr_cnt_reg  <= '0;
        wr_addr_reg <= dst_base;
      end else if (rd_vld) begin
        wr_cnt_reg  <= wr_cnt_reg + LEN_W'(1);
        wr_addr_reg <= wr_addr_reg + INC;
      end
      if (rd_vld) begin
        addrb_reg <= wr_addr_reg;
        dinb_reg  <= douta;
      end
    end
  end

`ifdef BRAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= '0;
    end else if (enb_reg) begin
      checksum_reg <= checksum_reg + dinb_reg;
    end
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_bram_block_copy.sv
// Bench for bram_block_copy: two instances (RD_LAT 1 and 3) driven in parallel, checked every cycle
// against a job-schedule model, plus literal expectations for the directed scenarios.
module tb_bram_block_copy;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] len;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [31:0] doutb_tie;

  logic        ready_s [2];
  logic        done_s  [2];
  logic        clka_s  [2];
  logic        clkb_s  [2];
  logic        rsta_s  [2];
  logic        rstb_s  [2];
  logic        ena_s   [2];
  logic        enb_s   [2];
  logic [31:0] addra_s [2];
  logic [31:0] addrb_s [2];
  logic [31:0] dina_s  [2];
  logic [31:0] dinb_s  [2];
  logic [31:0] douta_s [2];
  logic [3:0]  wea_s   [2];
  logic [3:0]  web_s   [2];
`ifdef BRAM_COPY_CHECKSUM_EN
  logic [31:0] csum_s  [2];
`endif

  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model job state per instance
  bit          act [2];
  bit          pristine [2];
  int          t0 [2];
  int          jlen [2];
  logic [31:0] jsrc [2];
  logic [31:0] jdst [2];
  bit          start_prev;

  // observations since the last accepted job
  int          done_rel [2];
  int          rlow [2];
  int          ena_cnt [2];
  int          wcnt [2];
  int          done_tot [2];
  logic [31:0] ena_a0 [2];
  logic [31:0] ena_a1 [2];
  logic [31:0] w_first_a [2];
  logic [31:0] w_first_d [2];
  logic [31:0] w_last_a [2];
  logic [31:0] w_last_d [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_u
    localparam int L = (gi == 0) ? 1 : 3;
    logic [31:0] rd_pipe [L];

    // port-A memory with L cycles of read latency; idle cycles return a marker word
    always @(posedge clk) begin
      rd_pipe[0] <= ena_s[gi] ? mem[addra_s[gi][9:2]] : 32'hDEAD_BEEF;
      for (int j = 1; j < L; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign douta_s[gi] = rd_pipe[L-1];

    bram_block_copy #(
      .DATA_W(32), .ADDR_W(32), .LEN_W(16), .ADDR_INC(4), .RD_LAT(L)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .src_base(src_base), .dst_base(dst_base),
      .ready(ready_s[gi]), .done(done_s[gi]),
      .clka(clka_s[gi]), .clkb(clkb_s[gi]), .rsta(rsta_s[gi]), .rstb(rstb_s[gi]),
      .ena(ena_s[gi]), .addra(addra_s[gi]), .dina(dina_s[gi]), .wea(wea_s[gi]),
      .douta(douta_s[gi]),
      .enb(enb_s[gi]), .addrb(addrb_s[gi]), .dinb(dinb_s[gi]), .web(web_s[gi]),
`ifdef BRAM_COPY_CHECKSUM_EN
      .checksum(csum_s[gi]),
`endif
      .doutb(doutb_tie)
    );
  end

  function automatic int lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int done_t(int k);
    return (jlen[k] == 0) ? 1 : jlen[k] + lat(k) + 2;
  endfunction

  function automatic bit m_ready(int k);
    int t = cyc - t0[k];
    if (!act[k] || jlen[k] == 0) return 1'b1;
    return !(t >= 1 && t <= jlen[k] + lat(k) + 1);
  endfunction

  function automatic bit m_done(int k);
    return act[k] && (cyc - t0[k] == done_t(k));
  endfunction

  function automatic bit m_ena(int k);
    int t = cyc - t0[k];
    return act[k] && t >= 1 && t <= jlen[k];
  endfunction

  function automatic bit m_enb(int k);
    int t = cyc - t0[k];
    return act[k] && t >= lat(k) + 2 && t <= jlen[k] + lat(k) + 1;
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  function automatic logic [31:0] m_sum(int k);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < jlen[k]; i++) s = s + word_at(jsrc[k] + 32'(i) * 32'd4);
    return s;
  endfunction

  task automatic check(string name, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u%0d cyc=%0d got=%h exp=%h", name, k, cyc, got, exp);
    end
  endtask

  task automatic compare(int k);
    int t = cyc - t0[k];
    int i;
    check("ready", k, 32'(ready_s[k]), 32'(m_ready(k)));
    check("done", k, 32'(done_s[k]), 32'(m_done(k)));
    check("ena", k, 32'(ena_s[k]), 32'(m_ena(k)));
    check("enb", k, 32'(enb_s[k]), 32'(m_enb(k)));
    check("web", k, 32'(web_s[k]), m_enb(k) ? 32'hF : 32'h0);
    check("dina_wea", k, dina_s[k] | 32'(wea_s[k]), 32'h0);
    if (m_ena(k)) check("addra", k, addra_s[k], jsrc[k] + 32'(t - 1) * 32'd4);
    if (m_enb(k)) begin
      i = t - lat(k) - 2;
      check("addrb", k, addrb_s[k], jdst[k] + 32'(i) * 32'd4);
      check("dinb", k, dinb_s[k], word_at(jsrc[k] + 32'(i) * 32'd4));
    end
    if (pristine[k]) begin
      check("rst_addra", k, addra_s[k], 32'h0);
      check("rst_addrb", k, addrb_s[k], 32'h0);
      check("rst_dinb", k, dinb_s[k], 32'h0);
    end
`ifdef BRAM_COPY_CHECKSUM_EN
    if (pristine[k]) check("csum_rst", k, csum_s[k], 32'h0);
    else if (act[k] && t >= done_t(k)) check("csum", k, csum_s[k], m_sum(k));
`endif
    if (done_s[k] === 1'b1) begin
      done_tot[k]++;
      if (act[k] && done_rel[k] < 0) done_rel[k] = t;
    end
    if (act[k]) begin
      if (ready_s[k] === 1'b0) rlow[k]++;
      if (ena_s[k] === 1'b1) begin
        if (ena_cnt[k] == 0) ena_a0[k] = addra_s[k];
        if (ena_cnt[k] == 1) ena_a1[k] = addra_s[k];
        ena_cnt[k]++;
      end
      if (enb_s[k] === 1'b1) begin
        if (wcnt[k] == 0) begin
          w_first_a[k] = addrb_s[k];
          w_first_d[k] = dinb_s[k];
        end
        w_last_a[k] = addrb_s[k];
        w_last_d[k] = dinb_s[k];
        wcnt[k]++;
      end
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        act[k] = 1'b0;
        pristine[k] = 1'b1;
      end else if (start && !start_prev && m_ready(k)) begin
        act[k] = 1'b1;
        pristine[k] = 1'b0;
        t0[k] = cyc;
        jlen[k] = int'(len);
        jsrc[k] = src_base;
        jdst[k] = dst_base;
        done_rel[k] = -1;
        rlow[k] = 0;
        ena_cnt[k] = 0;
        wcnt[k] = 0;
      end
    end
    start_prev = start;
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) compare(k);
  endtask

  task automatic launch(int n, logic [31:0] s, logic [31:0] d);
    len = 16'(n);
    src_base = s;
    dst_base = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int d0, d1;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    src_base = '0;
    dst_base = '0;
    doutb_tie = '0;
    start_prev = 1'b0;
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0;
      pristine[k] = 1'b1;
      t0[k] = 0;
      jlen[k] = 0;
      done_tot[k] = 0;
      done_rel[k] = -1;
    end
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;

    // reset held 3 cycles
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // len=4 copy 0x000 -> 0x100
    launch(4, 32'h0, 32'h100);
    repeat (12) tick();
    check("lit_done_c", 0, 32'(done_rel[0]), 32'd7);
    check("lit_ready_low", 0, 32'(rlow[0]), 32'd6);
    check("lit_ena_cnt", 0, 32'(ena_cnt[0]), 32'd4);
    check("lit_ena_a1", 0, ena_a1[0], 32'h4);
    check("lit_wcnt", 0, 32'(wcnt[0]), 32'd4);
    check("lit_w_first", 0, {w_first_a[0][23:0], w_first_d[0][7:0]}, 32'h00010011);
    check("lit_w_last", 0, {w_last_a[0][23:0], w_last_d[0][7:0]}, 32'h00010C44);
    check("lit_done_c", 1, 32'(done_rel[1]), 32'd9);
`ifdef BRAM_COPY_CHECKSUM_EN
    check("lit_csum", 0, csum_s[0], 32'hAA);
`endif

    // len=0: immediate done, no BRAM traffic
    launch(0, 32'h40, 32'h80);
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      check("lit_len0_done", k, 32'(done_rel[k]), 32'd1);
      check("lit_len0_rlow", k, 32'(rlow[k]), 32'd0);
      check("lit_len0_ena", k, 32'(ena_cnt[k] + wcnt[k]), 32'd0);
    end

    // start held high 20 cycles -> exactly one job
    d0 = done_tot[0];
    d1 = done_tot[1];
    len = 16'd10;
    src_base = 32'h20;
    dst_base = 32'h300;
    start = 1'b1;
    repeat (20) tick();
    start = 1'b0;
    repeat (5) tick();
    check("lit_hold_one", 0, 32'(done_tot[0] - d0), 32'd1);
    check("lit_hold_one", 1, 32'(done_tot[1] - d1), 32'd1);

    // a fresh start edge while busy is ignored
    d0 = done_tot[0];
    d1 = done_tot[1];
    launch(10, 32'h60, 32'h380);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("lit_busy_one", 0, 32'(done_tot[0] - d0), 32'd1);
    check("lit_busy_one", 1, 32'(done_tot[1] - d1), 32'd1);

    // reset during c3 of a len=8 job
    d0 = done_tot[0];
    d1 = done_tot[1];
    launch(8, 32'h100, 32'h200);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();
    check("lit_rst_nodone", 0, 32'(done_tot[0] - d0), 32'd0);
    check("lit_rst_nodone", 1, 32'(done_tot[1] - d1), 32'd0);
    launch(3, 32'h10, 32'h30);
    repeat (10) tick();
    check("lit_after_rst", 0, 32'(done_tot[0] - d0), 32'd1);
    check("lit_after_rst", 1, 32'(done_tot[1] - d1), 32'd1);

    // address wrap
    launch(2, 32'hFFFF_FFFC, 32'h200);
    repeat (10) tick();
    check("lit_wrap_a0", 1, ena_a0[1], 32'hFFFF_FFFC);
    check("lit_wrap_a1", 1, ena_a1[1], 32'h0);
    check("lit_wrap_done", 1, 32'(done_rel[1]), 32'd7);
    check("lit_wrap_done", 0, 32'(done_rel[0]), 32'd5);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      start = rst ? 1'b0 : ($urandom_range(0, 2) == 0);
      len = 16'($urandom_range(0, 12));
      src_base = $urandom;
      dst_base = $urandom;
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
